// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Instruction-side sequencer for the multi-cycle CPU. Owns the PC, fetches
// one instruction at a time from instruction memory, holds it for the
// decoder/datapath while it executes, then selects the next PC from the
// decoder's branch/jump controls and the ALU flags.
//
// Handshakes:
//   imem: imem_req_o is high for the whole FETCH state with imem_addr_o held
//         at the PC; the transfer happens in the cycle imem_ack_i is high
//         (same-cycle ack is legal). imem_ack_i is ignored outside FETCH.
//   exec: instr_valid_o is high for the whole EXEC state; the datapath raises
//         exec_done_i for the cycle in which the branch/jump controls and ALU
//         flags are valid. That cycle retires the instruction (retire_o).
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   imem_req_o/addr_o   fetch request and address (address == pc_o)
//   imem_ack_i/data_i   fetch completion and instruction word
//   instr_o             latched instruction
//   instr_valid_o       high while in EXEC
//   exec_done_i         current instruction finished, controls valid
//   branch_i            decoder Branch
//   branch_type_i       0=BEQ 1=BLE 2=BLT 3=BNEZ
//   jump_i              0=none 1=J/JAL 2=JR 3=none
//   alu_zero_i/neg_i    ALU flags
//   rs_data_i           JR target
//   pc_o, link_o        current PC and PC+4
//   retire_o            one-cycle retire pulse
//   trap_o              one-cycle misaligned-target trap pulse
//   dbg_state_o         FSM state (0=FETCH, 1=EXEC)
//
// Build option: define MISALIGN_TRAP_EN to redirect misaligned targets to
// TRAP_VEC and pulse trap_o; otherwise target bits [1:0] are cleared and
// trap_o is tied low.
// -----------------------------------------------------------------------------
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0080
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  input  logic        exec_done_i,
  input  logic        branch_i,
  input  logic [1:0]  branch_type_i,
  input  logic [1:0]  jump_i,
  input  logic        alu_zero_i,
  input  logic        alu_neg_i,
  input  logic [31:0] rs_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] link_o,
  output logic        retire_o,
  output logic        trap_o,
  output logic        dbg_state_o
);

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_EXEC  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_instr;

  logic [31:0] w_pc4;
  logic [31:0] w_br_off;
  logic        w_taken;
  logic [31:0] w_target;
  logic [31:0] w_next_pc;
  logic        w_retire;
  logic        w_fetch_hs;

  // ---------------------------------------------------------------------------
  // Next-PC selection
  // ---------------------------------------------------------------------------
  assign w_pc4    = r_pc + 32'd4;
  assign w_br_off = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};

  always_comb begin
    w_taken = 1'b0;
    case (branch_type_i)
      2'd0:    w_taken = alu_zero_i;
      2'd1:    w_taken = alu_zero_i | alu_neg_i;
      2'd2:    w_taken = alu_neg_i & ~alu_zero_i;
      default: w_taken = ~alu_zero_i;
    endcase
  end

  // Jump beats branch; jump_i==3 falls through to the branch/sequential path.
  always_comb begin
    w_target = w_pc4;
    if (jump_i == 2'd2) begin
      w_target = rs_data_i;
    end else if (jump_i == 2'd1) begin
      w_target = {w_pc4[31:28], r_instr[25:0], 2'b00};
    end else if (branch_i && w_taken) begin
      w_target = w_pc4 + w_br_off;
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic w_misalign;
  assign w_misalign = |w_target[1:0];
  assign w_next_pc  = w_misalign ? TRAP_VEC : w_target;
  assign trap_o     = w_retire & w_misalign;
`else
  // TRAP_VEC only matters with the trap enabled; keep it referenced.
  logic [31:0] w_unused_trap_vec;
  assign w_unused_trap_vec = TRAP_VEC;
  assign w_next_pc = {w_target[31:2], 2'b00};
  assign trap_o    = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and handshake outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    imem_req_o    = 1'b0;
    instr_valid_o = 1'b0;
    w_retire      = 1'b0;
    w_fetch_hs    = 1'b0;
    case (r_state)
      ST_FETCH: begin
        imem_req_o = 1'b1;
        if (imem_ack_i) begin
          w_fetch_hs  = 1'b1;
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        instr_valid_o = 1'b1;
        if (exec_done_i) begin
          // A reset in the done cycle wins: no retire is reported.
          w_retire    = ~rst_i;
          w_state_nxt = ST_FETCH;
        end
      end
      default: w_state_nxt = ST_FETCH;
    endcase
  end

  // ---------------------------------------------------------------------------
  // PC and instruction registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pc    <= RESET_PC;
      r_instr <= 32'h0000_0000;
    end else begin
      if (w_fetch_hs) begin
        r_instr <= imem_data_i;
      end
      if (w_retire) begin
        r_pc <= w_next_pc;
      end
    end
  end

  assign imem_addr_o = r_pc;
  assign pc_o        = r_pc;
  assign link_o      = w_pc4;
  assign instr_o     = r_instr;
  assign retire_o    = w_retire;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer: directed test of pc_sequencer. Inputs are driven 1 time unit
// after the rising edge; outputs are sampled before the next rising edge.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_data_i = 32'h0;
  logic [31:0] instr_o;
  logic        instr_valid_o;
  logic        exec_done_i = 1'b0;
  logic        branch_i = 1'b0;
  logic [1:0]  branch_type_i = 2'd0;
  logic [1:0]  jump_i = 2'd0;
  logic        alu_zero_i = 1'b0;
  logic        alu_neg_i = 1'b0;
  logic [31:0] rs_data_i = 32'h0;
  logic [31:0] pc_o;
  logic [31:0] link_o;
  logic        retire_o;
  logic        trap_o;
  logic        dbg_state_o;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_instr;

  // ---------------------------------------------------------------------------
  // Clock / DUT
  // ---------------------------------------------------------------------------
  always #5 clk_i = ~clk_i;

  pc_sequencer #(
    .RESET_PC (32'h0000_0000),
    .TRAP_VEC (32'h0000_0080)
  ) u_dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_data_i   (imem_data_i),
    .instr_o       (instr_o),
    .instr_valid_o (instr_valid_o),
    .exec_done_i   (exec_done_i),
    .branch_i      (branch_i),
    .branch_type_i (branch_type_i),
    .jump_i        (jump_i),
    .alu_zero_i    (alu_zero_i),
    .alu_neg_i     (alu_neg_i),
    .rs_data_i     (rs_data_i),
    .pc_o          (pc_o),
    .link_o        (link_o),
    .retire_o      (retire_o),
    .trap_o        (trap_o),
    .dbg_state_o   (dbg_state_o)
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Holds off ack for wait_cyc cycles, then delivers data.
  task automatic do_fetch(input logic [31:0] data, input int wait_cyc);
    for (int i = 0; i < wait_cyc; i++) begin
      check_eq("fetch_state", {31'd0, dbg_state_o}, 32'd0);
      check_eq("fetch_req", {31'd0, imem_req_o}, 32'd1);
      check_eq("fetch_addr", imem_addr_o, exp_pc);
      check_eq("fetch_valid", {31'd0, instr_valid_o}, 32'd0);
      tick();
    end
    imem_ack_i  = 1'b1;
    imem_data_i = data;
    #1;
    check_eq("ack_req", {31'd0, imem_req_o}, 32'd1);
    check_eq("ack_addr", imem_addr_o, exp_pc);
    tick();
    imem_ack_i  = 1'b0;
    imem_data_i = $urandom;
    exp_instr   = data;
    check_eq("exec_state", {31'd0, dbg_state_o}, 32'd1);
    check_eq("exec_instr", instr_o, exp_instr);
    check_eq("exec_valid", {31'd0, instr_valid_o}, 32'd1);
    check_eq("exec_req", {31'd0, imem_req_o}, 32'd0);
  endtask

  // Waits wait_cyc cycles in EXEC (with a stray ack to prove it is ignored),
  // then signals done with the given controls and checks the next PC.
  task automatic do_exec(input int wait_cyc, input logic br, input logic [1:0] bt,
                         input logic [1:0] jmp, input logic z, input logic n,
                         input logic [31:0] rs, input logic [31:0] exp_next,
                         input logic exp_trap);
    for (int i = 0; i < wait_cyc; i++) begin
      imem_ack_i  = 1'b1;
      imem_data_i = 32'hDEAD_BEEF;
      #1;
      check_eq("wait_retire", {31'd0, retire_o}, 32'd0);
      check_eq("wait_link", link_o, exp_pc + 32'd4);
      tick();
      imem_ack_i = 1'b0;
      check_eq("wait_instr_hold", instr_o, exp_instr);
      check_eq("wait_state", {31'd0, dbg_state_o}, 32'd1);
    end
    exec_done_i   = 1'b1;
    branch_i      = br;
    branch_type_i = bt;
    jump_i        = jmp;
    alu_zero_i    = z;
    alu_neg_i     = n;
    rs_data_i     = rs;
    #1;
    check_eq("done_retire", {31'd0, retire_o}, 32'd1);
    check_eq("done_trap", {31'd0, trap_o}, {31'd0, exp_trap});
    tick();
    exec_done_i = 1'b0;
    branch_i    = 1'b0;
    jump_i      = 2'd0;
    alu_zero_i  = 1'b0;
    alu_neg_i   = 1'b0;
    rs_data_i   = $urandom;
    exp_pc      = exp_next;
    check_eq("after_retire", {31'd0, retire_o}, 32'd0);
    check_eq("after_trap", {31'd0, trap_o}, 32'd0);
    check_eq("after_state", {31'd0, dbg_state_o}, 32'd0);
    check_eq("next_pc", pc_o, exp_pc);
  endtask

  // Uses a JR to place the PC at an aligned address.
  task automatic set_pc(input logic [31:0] addr);
    do_fetch(32'h0000_0008, 0);
    do_exec(0, 1'b0, 2'd0, 2'd2, 1'b0, 1'b0, addr, addr, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  // {type, zero, neg} -> expected next PC from pc=0x20 with imm=1
  logic [1:0]  t5_type [9] = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3};
  logic        t5_z    [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic        t5_n    [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [31:0] t5_exp  [9] = '{32'h24, 32'h28, 32'h28,
                               32'h24, 32'h28, 32'h24,
                               32'h28, 32'h28, 32'h24};

  initial begin
    exp_pc    = 32'h0;
    exp_instr = 32'h0;

    // 1: reset state, delayed ack, sequential retire
    tick();
    tick();
    rst_i = 1'b0;
    check_eq("rst_pc", pc_o, 32'h0);
    check_eq("rst_req", {31'd0, imem_req_o}, 32'd1);
    check_eq("rst_instr", instr_o, 32'h0);
    check_eq("rst_valid", {31'd0, instr_valid_o}, 32'd0);
    check_eq("rst_retire", {31'd0, retire_o}, 32'd0);
    check_eq("rst_trap", {31'd0, trap_o}, 32'd0);
    do_fetch(32'h1234_5678, 3);
    do_exec(1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 32'h0, 32'h4, 1'b0);

    // 2: BEQ with imm=-1: taken loops back to itself, not taken falls through
    set_pc(32'h0000_0100);
    do_fetch(32'h1022_FFFF, 1);
    do_exec(0, 1'b1, 2'd0, 2'd0, 1'b1, 1'b0, 32'h0, 32'h0000_0100, 1'b0);
    do_fetch(32'h1022_FFFF, 0);
    do_exec(2, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0000_0104, 1'b0);

    // 3: J with branch also asserted; jump wins, upper PC bits kept
    set_pc(32'h3000_0010);
    do_fetch(32'h0800_0040, 0);
    check_eq("j_link", link_o, 32'h3000_0014);
    do_exec(0, 1'b1, 2'd0, 2'd1, 1'b1, 1'b0, 32'h0, 32'h3000_0100, 1'b0);

    // 4: JR aligned, then misaligned
    do_fetch(32'h0000_0008, 0);
    do_exec(0, 1'b0, 2'd0, 2'd2, 1'b0, 1'b0, 32'h0000_2468, 32'h0000_2468, 1'b0);
    do_fetch(32'h0000_0008, 0);
`ifdef MISALIGN_TRAP_EN
    do_exec(0, 1'b0, 2'd0, 2'd2, 1'b0, 1'b0, 32'h0000_2466, 32'h0000_0080, 1'b1);
`else
    do_exec(0, 1'b0, 2'd0, 2'd2, 1'b0, 1'b0, 32'h0000_2466, 32'h0000_2464, 1'b0);
`endif

    // 5: BLE/BLT/BNEZ condition table
    for (int k = 0; k < 9; k++) begin
      set_pc(32'h0000_0020);
      do_fetch(32'h1000_0001, k % 2);
      do_exec(k % 3, 1'b1, t5_type[k], 2'd0, t5_z[k], t5_n[k], 32'h0, t5_exp[k], 1'b0);
    end

    // jump_i==3 behaves as no jump: taken BNEZ applies
    set_pc(32'h0000_0020);
    do_fetch(32'h1000_0001, 0);
    do_exec(0, 1'b1, 2'd3, 2'd3, 1'b0, 1'b0, 32'h0000_0400, 32'h0000_0028, 1'b0);

    // 6: reset in EXEC with exec_done_i high
    set_pc(32'h0000_0040);
    do_fetch(32'hABCD_0001, 0);
    exec_done_i = 1'b1;
    jump_i      = 2'd2;
    rs_data_i   = 32'h0000_0500;
    rst_i       = 1'b1;
    #1;
    check_eq("rst_exec_retire", {31'd0, retire_o}, 32'd0);
    check_eq("rst_exec_trap", {31'd0, trap_o}, 32'd0);
    tick();
    rst_i       = 1'b0;
    exec_done_i = 1'b0;
    jump_i      = 2'd0;
    exp_pc      = 32'h0;
    check_eq("rst_exec_pc", pc_o, 32'h0);
    check_eq("rst_exec_state", {31'd0, dbg_state_o}, 32'd0);
    check_eq("rst_exec_req", {31'd0, imem_req_o}, 32'd1);
    check_eq("rst_exec_instr", instr_o, 32'h0);

    // PC wrap on the sequential path
    set_pc(32'hFFFF_FFFC);
    do_fetch(32'h0000_0000, 0);
    check_eq("wrap_link", link_o, 32'h0);
    do_exec(0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
